// File: rtl/datapath_xyz.sv
// Datapath for the X/Y/Z register machine driven by the external controle block.
// X takes operands from entrada, Y accumulates ALU results or shifts, and
// Z captures Y. Each command field is decoded independently every cycle; an
// illegal code holds only the affected register and raises the sticky erro flag.
module datapath_xyz #(
    parameter int LARG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      auxX,
    input  logic [2:0]      auxY,
    input  logic [1:0]      auxZ,
    input  logic            auxULA,
    input  logic [LARG-1:0] entrada,
    output logic [LARG-1:0] regX,
    output logic [LARG-1:0] regY,
    output logic [LARG-1:0] regZ,
    output logic            carry,
    output logic            zero,
    output logic            pronto,
    output logic            erro
);

    // X and Z command codes
    localparam logic [1:0] XZ_CLEAR = 2'b00;
    localparam logic [1:0] XZ_LOAD  = 2'b01;
    localparam logic [1:0] XZ_HOLD  = 2'b10;

    // Y command codes
    localparam logic [2:0] Y_CLEAR = 3'b000;
    localparam logic [2:0] Y_LOAD  = 3'b001;
    localparam logic [2:0] Y_HOLD  = 3'b010;
    localparam logic [2:0] Y_SHL   = 3'b011;
    localparam logic [2:0] Y_SHR   = 3'b100;

    // ALU: the extra top bit is the carry-out on add. On subtract the
    // zero-extended difference wraps exactly when regX > regY, so the same bit
    // is the borrow.
    function automatic logic [LARG:0] ula(input logic            sub,
                                          input logic [LARG-1:0] y,
                                          input logic [LARG-1:0] x);
        logic [LARG:0] r;
        if (sub)
            r = {1'b0, y} - {1'b0, x};
        else
            r = {1'b0, y} + {1'b0, x};
        return r;
    endfunction

    logic [LARG:0]   ula_res;
    logic [LARG-1:0] next_x;
    logic [LARG-1:0] next_y;
    logic [LARG-1:0] next_z;
    logic            next_carry;
    logic            illegal;

    assign ula_res = ula(auxULA, regY, regX);

    // Next X from its command; unknown code behaves as hold
    always_comb begin
        next_x = regX;
        case (auxX)
            XZ_CLEAR: next_x = '0;
            XZ_LOAD:  next_x = entrada;
            XZ_HOLD:  next_x = regX;
            default:  next_x = regX;
        endcase
    end

    // Next Y and carry; carry moves only when Y loads an ALU result
    always_comb begin
        next_y     = regY;
        next_carry = carry;
        case (auxY)
            Y_CLEAR: next_y = '0;
            Y_LOAD: begin
                next_y     = ula_res[LARG-1:0];
                next_carry = ula_res[LARG];
            end
            Y_HOLD:  next_y = regY;
            Y_SHL:   next_y = {regY[LARG-2:0], 1'b0};
            Y_SHR:   next_y = {1'b0, regY[LARG-1:1]};
            default: next_y = regY;
        endcase
    end

    // Next Z from its command; Z loads the value Y holds before this edge
    always_comb begin
        next_z = regZ;
        case (auxZ)
            XZ_CLEAR: next_z = '0;
            XZ_LOAD:  next_z = regY;
            XZ_HOLD:  next_z = regZ;
            default:  next_z = regZ;
        endcase
    end

    // Any field carrying an unused code flags an illegal command this cycle
    always_comb begin
        illegal = 1'b0;
        if (auxX == 2'b11 || auxZ == 2'b11 || auxY > Y_SHR)
            illegal = 1'b1;
    end

    // Register bank: all three registers and carry update together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regX  <= '0;
            regY  <= '0;
            regZ  <= '0;
            carry <= 1'b0;
        end else begin
            regX  <= next_x;
            regY  <= next_y;
            regZ  <= next_z;
            carry <= next_carry;
        end
    end

    // Status flags: pronto pulses after a Z load, erro latches until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pronto <= 1'b0;
            erro   <= 1'b0;
        end else begin
            pronto <= (auxZ == XZ_LOAD);
            erro   <= erro | illegal;
        end
    end

    assign zero = (regY == '0);

endmodule

// File: tb/tb_datapath_xyz.sv
// Bench for datapath_xyz: directed sequences followed by random commands,
// checked every cycle against an arithmetic reference model.
module tb_datapath_xyz;

    localparam int LARG = 8;
    localparam int MOD  = 1 << LARG;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      auxX;
    logic [2:0]      auxY;
    logic [1:0]      auxZ;
    logic            auxULA;
    logic [LARG-1:0] entrada;
    logic [LARG-1:0] regX, regY, regZ;
    logic            carry, zero, pronto, erro;

    datapath_xyz #(.LARG(LARG)) dut (
        .clk(clk), .rst_n(rst_n), .auxX(auxX), .auxY(auxY), .auxZ(auxZ),
        .auxULA(auxULA), .entrada(entrada), .regX(regX), .regY(regY),
        .regZ(regZ), .carry(carry), .zero(zero), .pronto(pronto), .erro(erro)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // reference state
    int mx, my, mz;
    int mc, mp, me;

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference model: apply one edge's worth of commands to the model state
    task automatic model_edge(input int r, input int ax, input int ay, input int az,
                              input int op, input int ent);
        int nx, ny, nz, nc;
        if (r == 0) begin
            mx = 0; my = 0; mz = 0; mc = 0; mp = 0; me = 0;
            return;
        end
        nx = mx; ny = my; nz = mz; nc = mc;
        if (ax == 0) nx = 0;
        else if (ax == 1) nx = ent;
        if (ay == 0) ny = 0;
        else if (ay == 1) begin
            if (op == 0) begin
                ny = (my + mx) % MOD;
                nc = (my + mx >= MOD) ? 1 : 0;
            end else begin
                ny = (my - mx + MOD) % MOD;
                nc = (mx > my) ? 1 : 0;
            end
        end
        else if (ay == 3) ny = (my * 2) % MOD;
        else if (ay == 4) ny = my / 2;
        if (az == 0) nz = 0;
        else if (az == 1) nz = my;
        if (ax == 3 || az == 3 || ay > 4) me = 1;
        mp = (az == 1) ? 1 : 0;
        mx = nx; my = ny; mz = nz; mc = nc;
    endtask

    task automatic check_all();
        check("regX", int'(regX), mx);
        check("regY", int'(regY), my);
        check("regZ", int'(regZ), mz);
        check("carry", int'(carry), mc);
        check("zero", int'(zero), (my == 0) ? 1 : 0);
        check("pronto", int'(pronto), mp);
        check("erro", int'(erro), me);
    endtask

    // drive one cycle of commands, clock it, then compare against the model
    task automatic step(input int r, input int ax, input int ay, input int az,
                        input int op, input int ent);
        rst_n   = r[0];
        auxX    = ax[1:0];
        auxY    = ay[2:0];
        auxZ    = az[1:0];
        auxULA  = op[0];
        entrada = ent[LARG-1:0];
        @(posedge clk);
        #1;
        model_edge(r, ax, ay, az, op, ent);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; auxX = 2'b10; auxY = 3'b010; auxZ = 2'b10;
        auxULA = 1'b0; entrada = '0;

        // reset state
        step(0, 2, 2, 2, 0, 0);
        check("reset_zero", int'(zero), 1);

        // controle sequence, steps 0..4
        step(1, 1, 0, 0, 0, 5);
        check("seq0_x", int'(regX), 5);
        step(1, 1, 1, 2, 0, 3);
        check("seq1_y", int'(regY), 5);
        check("seq1_x", int'(regX), 3);
        step(1, 2, 1, 2, 0, 0);
        check("seq2_y", int'(regY), 8);
        step(1, 2, 4, 2, 0, 0);
        check("seq3_y", int'(regY), 4);
        step(1, 0, 0, 1, 0, 0);
        check("seq4_z", int'(regZ), 4);
        check("seq4_pronto", int'(pronto), 1);
        step(1, 2, 2, 2, 0, 0);
        check("pronto_drop", int'(pronto), 0);

        // add overflow and subtract borrow
        step(0, 2, 2, 2, 0, 0);
        step(1, 1, 0, 2, 0, 1);          // X=1
        step(1, 2, 1, 2, 1, 0);          // Y = 0-1 = 255
        check("y255", int'(regY), 255);
        step(1, 2, 1, 2, 0, 0);          // Y = 255+1 = 0
        check("ovf_y", int'(regY), 0);
        check("ovf_carry", int'(carry), 1);
        check("ovf_zero", int'(zero), 1);
        step(1, 1, 1, 2, 0, 2);          // Y = 0+1 = 1, X=2
        step(1, 2, 1, 2, 1, 0);          // Y = 1-2 = 255
        check("brw_y", int'(regY), 255);
        check("brw_carry", int'(carry), 1);

        // shifts with X/Z hold
        step(1, 1, 0, 1, 0, 8'h81);
        step(1, 2, 1, 2, 0, 0);          // Y = 0x81
        step(1, 2, 3, 2, 0, 0);
        check("shl", int'(regY), 8'h02);
        check("shl_x", int'(regX), 8'h81);
        step(1, 2, 0, 2, 0, 0);
        step(1, 2, 1, 2, 0, 0);          // Y = 0x81
        step(1, 2, 4, 2, 0, 0);
        check("shr", int'(regY), 8'h40);

        // illegal Y code with a legal X load, then idle
        step(1, 1, 7, 2, 0, 9);
        check("ill_x", int'(regX), 9);
        check("ill_y", int'(regY), 8'h40);
        check("ill_erro", int'(erro), 1);
        for (int i = 0; i < 10; i++) step(1, 2, 2, 2, 0, 0);
        check("erro_sticky", int'(erro), 1);
        step(1, 3, 2, 3, 0, 0);          // illegal X and Z codes hold

        // simultaneous Y load and Z load
        step(1, 1, 0, 2, 0, 6);
        step(1, 1, 1, 2, 0, 2);          // Y=6, X=2
        step(1, 2, 1, 1, 0, 0);
        check("same_edge_z", int'(regZ), 6);
        check("same_edge_y", int'(regY), 8);

        // reset mid-sequence
        step(1, 1, 0, 0, 0, 5);
        step(1, 1, 1, 2, 0, 3);
        step(0, 2, 1, 2, 0, 0);
        check("midrst_y", int'(regY), 0);
        check("midrst_erro", int'(erro), 0);
        check("midrst_zero", int'(zero), 1);
        step(1, 1, 2, 2, 0, 77);         // first edge out of reset executes
        check("post_rst_x", int'(regX), 77);

        // random commands, occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 0 : 1,
                 $urandom_range(0, 3), $urandom_range(0, 7),
                 $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, MOD - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/datapath_xyz.md
DATAPATH_XYZ -- requirements
Module: datapath_xyz

Interface
REQ-001 SHALL have parameter: LARG, 8, data width of X, Y, Z, entrada and ULA.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: auxX  input  2  X command: 00 clear, 01 load, 10 hold.
REQ-005 SHALL have port: auxY  input  3  Y command: 000 clear, 001 load, 010 hold, 011 shift left, 100 shift right.
REQ-006 SHALL have port: auxZ  input  2  Z command: 00 clear, 01 load, 10 hold.
REQ-007 SHALL have port: auxULA  input  1  ALU op: 0 add, 1 subtract.
REQ-008 SHALL have port: entrada  input  LARG  operand loaded into X.
REQ-009 SHALL have port: regX, regY, regZ  output  LARG each  register contents.
REQ-010 SHALL have port: carry  output  1  carry/borrow of the last Y load.
REQ-011 SHALL have port: zero  output  1  high when regY is 0.
REQ-012 SHALL have port: pronto  output  1  one-cycle pulse after each Z load.
REQ-013 SHALL have port: erro  output  1  sticky illegal-command flag.

Function
REQ-014 SHALL define ULA result = regY + regX (auxULA=0) or regY - regX (auxULA=1), LARG bits, modulo 2^LARG.
REQ-015 SHALL evaluate every register's next value from pre-edge values of regX, regY and regZ; all three update on the same edge.
REQ-016 X: clear -> 0; load -> entrada; hold -> unchanged.
REQ-017 Y: clear -> 0; load -> ULA result; hold -> unchanged.
REQ-018 Y: shift left -> {regY[LARG-2:0],0}; shift right -> {0,regY[LARG-1:1]} (logical, zero fill).
REQ-019 Z: clear -> 0; load -> pre-edge regY; hold -> unchanged.
REQ-020 carry SHALL update only on a Y load: add -> carry-out bit LARG; subtract -> borrow (1 when regX > regY); otherwise hold.
REQ-021 zero SHALL be combinational from regY (1 iff regY == 0).
REQ-022 pronto SHALL be 1 for exactly the cycle after any edge with auxZ=01, else 0; consecutive Z loads give pronto high on consecutive cycles.
REQ-023 Illegal codes SHALL be executed as hold for the affected register only: auxX=11, auxZ=11, auxY in 101..111.
REQ-024 erro SHALL set on the edge where any illegal code is sampled and stay 1 until reset.
REQ-025 Other registers SHALL execute their legal commands normally in a cycle with an illegal code on one field.
REQ-026 Latency: every command SHALL take effect on the edge on which it is sampled, so outputs reflect it in the next cycle.
REQ-027 SHALL contain no internal FSM beyond these registers; sequencing belongs to controle, whose step codes 0000..0100 are consumed one per cycle.

Reset
REQ-028 With rst_n=0 at an edge: regX, regY, regZ, carry, pronto, erro SHALL all go to 0 and zero to 1, overriding all commands.
REQ-029 Reset asserted mid-sequence SHALL discard partial results; the first edge with rst_n=1 executes the commands present on that edge.
REQ-030 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-031 Controle steps 0..4 in sequence, entrada=5, then 3 on step 1, auxULA=0: X=5,Y=0,Z=0 -> X=3,Y=5 -> Y=8 -> Y=4 -> X=0,Y=0,Z=4, pronto=1 on the next cycle.
REQ-032 LARG=8, X=1, Y=255, Y load with add -> Y=0, carry=1, zero=1; then X=2,Y=1, subtract -> Y=255, carry=1.
REQ-033 Y=8'b1000_0001: shift left -> 0000_0010; shift right from 1000_0001 -> 0100_0000; X and Z unchanged with hold.
REQ-034 auxY=111 with auxX=01, entrada=9 -> Y unchanged, X=9, erro=1 and stays 1 for 10 more idle cycles.
REQ-035 Same edge: auxY=001 and auxZ=01 with Y=6, X=2 -> Z=6 (old Y), Y=8.
REQ-036 rst_n=0 during step 2 with nonzero registers -> all registers 0, erro=0, zero=1 on the next cycle.
